// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing the USB UART byte-write port
//
// Grants the UART write port to one of NUM_REQ byte-stream requesters at a
// time. A grant lasts until the owner delivers a byte flagged last, or until
// the owner holds req_valid low for STALL_CYCLES consecutive cycles mid-packet.
// The next search starts one past the previous owner, so arbitration is
// round-robin at packet granularity.
//
// Ports:
//   clk_48mhz    system clock, rising edge
//   reset        synchronous active-high reset
//   req_valid    per-requester byte valid            [NUM_REQ]
//   req_data     per-requester byte, 8 bits each     [8*NUM_REQ]
//   req_last     per-requester end-of-packet flag    [NUM_REQ]
//   req_ready    per-requester accept (combinational)[NUM_REQ]
//   uart_di      byte to the UART (registered)
//   uart_we      UART write enable (registered)
//   uart_wait    UART busy, holds the pending write
//   busy         arbiter not idle
//   grant_id     current owner index, valid while busy
//   stall_abort  one-cycle pulse when a grant is revoked by timeout

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int STALL_CYCLES = 255,
    parameter int GID_W        = 2
) (
    input  logic                   clk_48mhz,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_di,
    output logic                   uart_we,
    input  logic                   uart_wait,
    output logic                   busy,
    output logic [GID_W-1:0]       grant_id,
    output logic                   stall_abort
);

    localparam int CNT_W = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               uart_we_q, uart_we_d;
    logic [7:0]         uart_di_q, uart_di_d;
    logic               stall_abort_q, stall_abort_d;

    // Owner's request signals, muxed by grant_id_q.
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic               sel_last;

    // Round-robin pick: first valid at or above the pointer, else first valid
    // from index 0 (the wrap-around part of the search).
    logic               found_hi, found_lo;
    logic [GID_W-1:0]   pick_hi, pick_lo, pick;

    logic [GID_W-1:0]   next_id;
    logic               take;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
            end
        end
    end

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req_valid[i] && (GID_W'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                pick_hi  = GID_W'(i);
            end
            if (!found_lo && req_valid[i]) begin
                found_lo = 1'b1;
                pick_lo  = GID_W'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    assign next_id = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // A byte is accepted only when no write is pending, which also enforces
    // the idle cycle between consecutive UART writes.
    assign take = (state_q == SEND) && sel_valid && !uart_we_q && !uart_wait;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GID_W'(i)) begin
                req_ready[i] = take;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        stall_cnt_d   = stall_cnt_q;
        uart_we_d     = uart_we_q;
        uart_di_d     = uart_di_q;
        stall_abort_d = 1'b0;

        // Pending write completes this cycle; drop the enable afterwards.
        if (uart_we_q && !uart_wait) begin
            uart_we_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                stall_cnt_d = '0;
                if (|req_valid) begin
                    grant_id_d = pick;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (take) begin
                    uart_di_d   = sel_data;
                    uart_we_d   = 1'b1;
                    stall_cnt_d = '0;
                    if (sel_last) begin
                        state_d = FLUSH;
                    end
                end else if (!sel_valid && !uart_we_q) begin
                    // Abort on the cycle the count reaches STALL_CYCLES, so the
                    // registered pulse appears STALL_CYCLES cycles after the
                    // owner's last write completed.
                    if (stall_cnt_q == STALL_MAX - 1'b1) begin
                        stall_abort_d = 1'b1;
                        stall_cnt_d   = '0;
                        ptr_d         = next_id;
                        state_d       = IDLE;
                    end else if (stall_cnt_q != STALL_MAX) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (uart_we_q && !uart_wait) begin
                    ptr_d   = next_id;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            ptr_q         <= '0;
            stall_cnt_q   <= '0;
            uart_we_q     <= 1'b0;
            uart_di_q     <= 8'h00;
            stall_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            stall_cnt_q   <= stall_cnt_d;
            uart_we_q     <= uart_we_d;
            uart_di_q     <= uart_di_d;
            stall_abort_q <= stall_abort_d;
        end
    end

    assign uart_we     = uart_we_q;
    assign uart_di     = uart_di_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_id_q;
    assign stall_abort = stall_abort_q;

endmodule
